// File: rtl/pic_host_sequencer.sv
`default_nettype none
// ============================================================================
// Module : pic_host_sequencer
// Brief  : CPU-side bus initiator for an 8259 PIC (ICW programming, OCW/status
//          commands, two-pulse INTA acknowledge). Define PIC_HOST_LOCK_EN to add LOCK.
// Rev    : 1.0
// ============================================================================
module pic_host_sequencer #(
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       INT,
  output logic       CS,
  output logic       WR,
  output logic       RD,
  output logic       A0,
  output logic       INTA,
  input  logic [7:0] D_in,
  output logic [7:0] D_out,
  output logic       D_oe,
  input  logic       init_start,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw3,
  input  logic [7:0] icw4,
  output logic       busy,
  output logic       init_done,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_read,
  input  logic       cmd_a0,
  input  logic [7:0] cmd_data,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       int_enable,
  output logic [7:0] vector,
  output logic       vector_valid
`ifdef PIC_HOST_LOCK_EN
  ,
  output logic       LOCK
`endif
);

  localparam logic [3:0] ST_IDLE     = 4'd0;
  localparam logic [3:0] ST_SETUP    = 4'd1;
  localparam logic [3:0] ST_STROBE   = 4'd2;
  localparam logic [3:0] ST_HOLD     = 4'd3;
  localparam logic [3:0] ST_GAP      = 4'd4;
  localparam logic [3:0] ST_ACK1     = 4'd5;
  localparam logic [3:0] ST_ACK_GAP  = 4'd6;
  localparam logic [3:0] ST_ACK2     = 4'd7;
  localparam logic [3:0] ST_ACK_DONE = 4'd8;

  localparam int MAX_W = (PULSE_W > GAP_W) ? PULSE_W : GAP_W;
  localparam int CNT_W = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(GAP_W - 1);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       step_q, step_d;
  logic             init_q, init_d;
  logic             init_done_q, init_done_d;
  logic             is_read_q, is_read_d;
  logic             a0_q, a0_d;
  logic [7:0]       data_q, data_d;
  logic [7:0]       rd_data_q, rd_data_d;
  logic [7:0]       vector_q, vector_d;
  logic [7:0]       icw_q [4];
  logic [7:0]       icw_d [4];
  logic             has_next_w;
  logic [1:0]       next_step_w;
  logic             lock_w;

`ifdef PIC_HOST_LOCK_EN
  assign lock_w = (state_q == ST_ACK1) || (state_q == ST_ACK_GAP) ||
                  (state_q == ST_ACK2) || (state_q == ST_ACK_DONE);
  assign LOCK   = lock_w;
`else
  assign lock_w = 1'b0;
`endif

  assign busy      = (state_q != ST_IDLE);
  assign init_done = init_done_q;
  assign rd_data   = rd_data_q;
  assign vector    = vector_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      step_q      <= 2'd0;
      init_q      <= 1'b0;
      init_done_q <= 1'b0;
      is_read_q   <= 1'b0;
      a0_q        <= 1'b0;
      data_q      <= 8'h00;
      rd_data_q   <= 8'h00;
      vector_q    <= 8'h00;
      icw_q       <= '{default: 8'h00};
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      step_q      <= step_d;
      init_q      <= init_d;
      init_done_q <= init_done_d;
      is_read_q   <= is_read_d;
      a0_q        <= a0_d;
      data_q      <= data_d;
      rd_data_q   <= rd_data_d;
      vector_q    <= vector_d;
      icw_q       <= icw_d;
    end
  end

  // Which ICW follows the current one: ICW3 only without SNGL, ICW4 only with IC4.
  always_comb begin
    has_next_w  = 1'b0;
    next_step_w = 2'd0;
    case (step_q)
      2'd0: begin has_next_w = 1'b1; next_step_w = 2'd1; end
      2'd1: begin
        if (!icw_q[0][1])     begin has_next_w = 1'b1; next_step_w = 2'd2; end
        else if (icw_q[0][0]) begin has_next_w = 1'b1; next_step_w = 2'd3; end
      end
      2'd2: if (icw_q[0][0])  begin has_next_w = 1'b1; next_step_w = 2'd3; end
      default: ;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    step_d      = step_q;
    init_d      = init_q;
    init_done_d = init_done_q;
    is_read_d   = is_read_q;
    a0_d        = a0_q;
    data_d      = data_q;
    rd_data_d   = rd_data_q;
    vector_d    = vector_q;
    icw_d       = icw_q;
    case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (init_start) begin
          icw_d       = '{icw1, icw2, icw3, icw4};
          step_d      = 2'd0;
          init_d      = 1'b1;
          init_done_d = 1'b0;
          is_read_d   = 1'b0;
          a0_d        = 1'b0;
          data_d      = icw1 | 8'h10;
          state_d     = ST_SETUP;
        end else if (INT && int_enable && init_done_q) begin
          state_d = ST_ACK1;
        end else if (cmd_valid && init_done_q) begin
          is_read_d = cmd_read;
          a0_d      = cmd_a0;
          data_d    = cmd_data;
          state_d   = ST_SETUP;
        end
      end
      ST_SETUP: begin cnt_d = '0; state_d = ST_STROBE; end
      ST_STROBE: begin
        if (cnt_q == PULSE_LAST) begin
          if (is_read_q) rd_data_d = D_in;
          state_d = ST_HOLD;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_HOLD: begin cnt_d = '0; state_d = ST_GAP; end
      ST_GAP: begin
        if (cnt_q != GAP_LAST) begin
          cnt_d = cnt_q + CNT_W'(1);
        end else if (init_q && has_next_w) begin
          step_d  = next_step_w;
          a0_d    = 1'b1;
          data_d  = icw_q[next_step_w];
          state_d = ST_SETUP;
        end else begin
          if (init_q) init_done_d = 1'b1;
          init_d  = 1'b0;
          state_d = ST_IDLE;
        end
      end
      ST_ACK1: begin
        if (cnt_q == PULSE_LAST) begin cnt_d = '0; state_d = ST_ACK_GAP; end
        else cnt_d = cnt_q + CNT_W'(1);
      end
      ST_ACK_GAP: begin
        if (cnt_q == GAP_LAST) begin cnt_d = '0; state_d = ST_ACK2; end
        else cnt_d = cnt_q + CNT_W'(1);
      end
      ST_ACK2: begin
        if (cnt_q == PULSE_LAST) begin vector_d = D_in; state_d = ST_ACK_DONE; end
        else cnt_d = cnt_q + CNT_W'(1);
      end
      ST_ACK_DONE: state_d = ST_IDLE;
      default:     state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    CS           = 1'b1;
    WR           = 1'b1;
    RD           = 1'b1;
    A0           = 1'b0;
    INTA         = 1'b1;
    D_oe         = 1'b0;
    D_out        = 8'h00;
    rd_valid     = 1'b0;
    vector_valid = 1'b0;
    cmd_ready    = 1'b0;
    case (state_q)
      ST_IDLE: cmd_ready = init_done_q && !init_start && !(INT && int_enable) && !lock_w;
      ST_SETUP, ST_STROBE, ST_HOLD: begin
        CS    = 1'b0;
        A0    = a0_q;
        D_oe  = !is_read_q;
        D_out = is_read_q ? 8'h00 : data_q;
        if (state_q == ST_STROBE) begin
          WR = is_read_q;
          RD = !is_read_q;
        end
        if (state_q == ST_HOLD) rd_valid = is_read_q;
      end
      ST_ACK1, ST_ACK2: INTA = 1'b0;
      ST_ACK_DONE:      vector_valid = 1'b1;
      default: ;
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_pic_host_sequencer.sv
`default_nettype none
// ============================================================================
// Module : tb_pic_host_sequencer
// Brief  : Scoreboard bench: drivers queue expected bus events, a negedge
//          monitor decodes the PIC pins and compares. Rev 1.0
// ============================================================================
`timescale 1ns/1ps
module tb_pic_host_sequencer;
  localparam int P   = 2;
  localparam int G   = 1;
  localparam int BUS = 2 + P + G;
  localparam int K_W = 0, K_R = 1, K_A = 2;

  typedef struct { int kind; int a0; int data; } exp_t;

  logic clk = 1'b0, reset = 1'b1, INT = 1'b0;
  logic CS, WR, RD, A0, INTA, D_oe, busy, init_done, cmd_ready, rd_valid, vector_valid;
  logic [7:0] D_in, D_out, rd_data, vector;
  logic init_start = 1'b0, cmd_valid = 1'b0, cmd_read = 1'b0, cmd_a0 = 1'b0, int_enable = 1'b0;
  logic [7:0] icw1 = 8'h0, icw2 = 8'h0, icw3 = 8'h0, icw4 = 8'h0, cmd_data = 8'h0;
`ifdef PIC_HOST_LOCK_EN
  logic LOCK;
`endif

  int   checks = 0, errors = 0;
  exp_t exp_q[$];
  bit   model_init_done = 1'b0;
  logic [7:0] rd_val = 8'h00, vec_val = 8'h00;

  int wr_run = 0, rd_run = 0, cs_run = 0, inta_run = 0, inta_pulses = 0, gap_run = 0;
  int plen [2];
  int w_a0, w_d, w_oe, r_a0, r_oe, ack_bad = 0;

  always #5 clk = ~clk;

  pic_host_sequencer #(.PULSE_W(P), .GAP_W(G)) dut (
    .clk(clk), .reset(reset), .INT(INT), .CS(CS), .WR(WR), .RD(RD), .A0(A0), .INTA(INTA),
    .D_in(D_in), .D_out(D_out), .D_oe(D_oe), .init_start(init_start),
    .icw1(icw1), .icw2(icw2), .icw3(icw3), .icw4(icw4), .busy(busy), .init_done(init_done),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read), .cmd_a0(cmd_a0),
    .cmd_data(cmd_data), .rd_data(rd_data), .rd_valid(rd_valid), .int_enable(int_enable),
    .vector(vector), .vector_valid(vector_valid)
`ifdef PIC_HOST_LOCK_EN
    , .LOCK(LOCK)
`endif
  );

  // PIC data model: the true byte appears only in the last strobe cycle.
  always_comb begin
    if (!RD)                     D_in = (rd_run == P) ? rd_val : ~rd_val;
    else if (!INTA && inta_pulses == 1) D_in = (inta_run == P) ? vec_val : ~vec_val;
    else if (!INTA)              D_in = ~vec_val;
    else                         D_in = 8'hA5;
  end

  task automatic chk(input string name, input int act, input int exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp_v, $time);
    end
  endtask

  task automatic fail(input string name);
    checks++;
    errors++;
    $display("FAIL %s at %0t", name, $time);
  endtask

  task automatic pop_exp(input int kind, output exp_t e, output bit ok);
    ok = 1'b0;
    e  = '{kind: -1, a0: 0, data: 0};
    if (exp_q.size() == 0) begin
      fail($sformatf("unexpected event kind %0d", kind));
    end else begin
      e = exp_q.pop_front();
      chk("event kind", kind, e.kind);
      ok = (e.kind == kind);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    bit ok;
    if (reset) begin
      wr_run = 0; rd_run = 0; cs_run = 0; inta_run = 0; inta_pulses = 0; gap_run = 0; ack_bad = 0;
    end else begin
      if (!WR) begin
        wr_run++; w_a0 = A0; w_d = D_out; w_oe = D_oe;
      end else if (wr_run != 0) begin
        chk("wr hold cs", CS, 0);
        chk("wr hold oe", D_oe, 1);
        chk("wr pulse", wr_run, P);
        pop_exp(K_W, e, ok);
        if (ok) begin
          chk("wr a0", w_a0, e.a0);
          chk("wr data", w_d, e.data);
          chk("wr oe", w_oe, 1);
        end
        wr_run = 0;
      end
      if (!RD) begin
        rd_run++; r_a0 = A0; r_oe = D_oe;
      end
      if (rd_valid) begin
        chk("rd hold strobe", RD, 1);
        chk("rd pulse", rd_run, P);
        pop_exp(K_R, e, ok);
        if (ok) begin
          chk("rd a0", r_a0, e.a0);
          chk("rd oe", r_oe, 0);
          chk("rd data", rd_data, e.data);
        end
        rd_run = 0;
      end
      if (!CS) cs_run++;
      else if (cs_run != 0) begin
        chk("cs low length", cs_run, 2 + P);
        cs_run = 0;
      end
      if (!INTA) begin
        inta_run++;
        if (!CS || D_oe) ack_bad = 1;
      end else begin
        if (inta_run != 0) begin
          if (inta_pulses < 2) plen[inta_pulses] = inta_run;
          inta_pulses++;
          inta_run = 0;
        end
        if (inta_pulses == 1) gap_run++;
      end
      if (vector_valid) begin
        pop_exp(K_A, e, ok);
        if (ok) chk("vector", vector, e.data);
        chk("inta pulses", inta_pulses, 2);
        chk("inta pulse1", plen[0], P);
        chk("inta gap", gap_run, G);
        chk("inta pulse2", plen[1], P);
        chk("ack bus quiet", ack_bad, 0);
        inta_pulses = 0; gap_run = 0; ack_bad = 0;
      end
    end
  end

  task automatic check_reset_outputs(input string tag);
    chk({tag, " CS"}, CS, 1);     chk({tag, " WR"}, WR, 1);
    chk({tag, " RD"}, RD, 1);     chk({tag, " INTA"}, INTA, 1);
    chk({tag, " A0"}, A0, 0);     chk({tag, " D_oe"}, D_oe, 0);
    chk({tag, " D_out"}, D_out, 0); chk({tag, " busy"}, busy, 0);
    chk({tag, " init_done"}, init_done, 0); chk({tag, " cmd_ready"}, cmd_ready, 0);
    chk({tag, " rd_data"}, rd_data, 0); chk({tag, " rd_valid"}, rd_valid, 0);
    chk({tag, " vector"}, vector, 0); chk({tag, " vector_valid"}, vector_valid, 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 500) begin @(negedge clk); n++; end
    if (busy) fail("busy timeout");
    repeat (2) @(negedge clk);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!cmd_ready && n < 500) begin @(negedge clk); n++; end
    if (!cmd_ready) fail("cmd_ready timeout");
    else @(negedge clk);
  endtask

  task automatic do_init(input logic [7:0] i1, i2, i3, i4);
    int n = 2, cyc = 0;
    exp_q.push_back('{kind: K_W, a0: 0, data: int'(i1 | 8'h10)});
    exp_q.push_back('{kind: K_W, a0: 1, data: int'(i2)});
    if (!i1[1]) begin exp_q.push_back('{kind: K_W, a0: 1, data: int'(i3)}); n++; end
    if (i1[0])  begin exp_q.push_back('{kind: K_W, a0: 1, data: int'(i4)}); n++; end
    icw1 = i1; icw2 = i2; icw3 = i3; icw4 = i4;
    init_start = 1'b1;
    @(negedge clk);
    init_start = 1'b0;
    chk("init_done cleared", init_done, 0);
    while (busy && cyc < 2000) begin cyc++; @(negedge clk); end
    chk("init busy cycles", cyc, n * BUS);
    chk("init_done set", init_done, 1);
    model_init_done = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_cmd(input bit rd, input bit a0, input logic [7:0] data);
    exp_q.push_back('{kind: rd ? K_R : K_W, a0: int'(a0), data: int'(data)});
    if (rd) rd_val = data;
    cmd_read = rd; cmd_a0 = a0; cmd_data = data; cmd_valid = 1'b1;
    wait_ready();
    cmd_valid = 1'b0;
    wait_idle();
  endtask

  task automatic do_int(input bit en, input logic [7:0] v);
    int n = 0;
    vec_val = v; int_enable = en; INT = 1'b1;
    if (en && model_init_done) begin
      exp_q.push_back('{kind: K_A, a0: 0, data: int'(v)});
      do begin @(negedge clk); n++; end while (INTA && n < 50);
      if (INTA) fail("inta timeout");
      INT = 1'b0;
      wait_idle();
    end else begin
      repeat (20) begin @(negedge clk); if (busy || !INTA) n++; end
      chk("no ack when disabled", n, 0);
      INT = 1'b0;
    end
    int_enable = 1'b0;
  endtask

  initial begin
    int n;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    reset = 1'b0;
    @(negedge clk);

    cmd_valid = 1'b1; n = 0;
    repeat (10) begin @(negedge clk); if (busy || cmd_ready) n++; end
    chk("no cmd before init", n, 0);
    cmd_valid = 1'b0;

    do_init(8'h13, 8'h20, 8'h00, 8'h01);
    do_init(8'h01, 8'h20, 8'h04, 8'h01);
    do_init(8'h03, 8'h28, 8'h04, 8'h01);
    do_init(8'h00, 8'h30, 8'h04, 8'h01);
    do_cmd(1'b0, 1'b1, 8'hFB);
    do_cmd(1'b1, 1'b0, 8'h05);
    do_int(1'b1, 8'h21);
    do_int(1'b0, 8'h33);

    // INT and a command together: acknowledge must win
    exp_q.push_back('{kind: K_A, a0: 0, data: 32'h44});
    exp_q.push_back('{kind: K_W, a0: 0, data: 32'h5C});
    vec_val = 8'h44; cmd_read = 1'b0; cmd_a0 = 1'b0; cmd_data = 8'h5C;
    INT = 1'b1; int_enable = 1'b1; cmd_valid = 1'b1;
    #1;
    chk("cmd_ready low with INT", cmd_ready, 0);
    n = 0;
    do begin @(negedge clk); n++; end while (INTA && n < 50);
    if (INTA) fail("priority inta timeout");
    INT = 1'b0; int_enable = 1'b0;
    wait_ready();
    cmd_valid = 1'b0;
    wait_idle();

    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 4))
        0: do_init(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        1: do_cmd(1'b0, 1'($urandom), 8'($urandom));
        2: do_cmd(1'b1, 1'($urandom), 8'($urandom));
        3: do_int(1'b1, 8'($urandom));
        default: do_int(1'b0, 8'($urandom));
      endcase
    end

    // Reset in the middle of ICW2
    icw1 = 8'h13; icw2 = 8'h20; icw4 = 8'h01;
    exp_q.push_back('{kind: K_W, a0: 0, data: 32'h13});
    init_start = 1'b1;
    @(negedge clk);
    init_start = 1'b0;
    repeat (6) @(negedge clk);
    chk("in icw2 strobe", WR, 0);
    reset = 1'b1;
    @(negedge clk);
    check_reset_outputs("midinit");
    exp_q.delete();
    model_init_done = 1'b0;
    reset = 1'b0;
    @(negedge clk);
    do_init(8'h11, 8'h40, 8'h02, 8'h03);
    do_cmd(1'b1, 1'b1, 8'h9E);

    repeat (5) @(negedge clk);
    chk("scoreboard drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end
endmodule
`default_nettype wire
